mmio_io_hub: RTL and testbench

- Parametrised memory-mapped I/O block on the CPU data bus; supersedes the fixed single-switch/single-LED pair.
- Provides N_IN debounced input channels (switch banks) and N_OUT writable output registers (LED banks).
- Adds a sticky change-status register with an interrupt line, byte-enable writes and a registered read path.
- Sits behind the MemOrIO address decoder, which asserts io_cs for the I/O window.

---
 rtl/mmio_io_pkg.sv | 27 ++
 rtl/io_debounce.sv | 70 +++++++
 rtl/mmio_io_hub.sv | 144 ++++++++++++++
 tb/tb_mmio_io_hub.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_io_pkg.sv
// mmio_io_pkg: shared address-map constants and helpers for mmio_io_hub.
//   REGION_BIT      : addr bit selecting input (0) or output (1) region
//   IDX_HI/IDX_LO   : channel index field within addr
//   STATUS_IDX      : input-region index decoded as the sticky status register
//   clog2()         : ceiling log2, used to size the debounce counter
package mmio_io_pkg;

    localparam int unsigned REGION_BIT = 5;
    localparam int unsigned IDX_HI     = 4;
    localparam int unsigned IDX_LO     = 2;
    localparam logic [2:0]  STATUS_IDX = 3'd7;

    typedef enum logic {
        REG_IN  = 1'b0,
        REG_OUT = 1'b1
    } region_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: one input channel -- 2-flop synchroniser plus optional debounce.
// Optional feature macro: IO_DEBOUNCE_EN (defined = counter-based debounce,
// undefined = debounced value is the synchroniser output).
// Ports:
//   clock, rst : clock, asynchronous active-low reset
//   raw        : raw asynchronous input
//   deb        : debounced value
//   change     : high in the cycle before the edge on which deb changes
module io_debounce
    import mmio_io_pkg::*;
#(
    parameter int unsigned W            = 16,
    parameter int unsigned DEBOUNCE_CYC = 20000
) (
    input  logic         clock,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] deb,
    output logic         change
);

    // sync2 doubles as the "last-sampled" value compared against sync1
    logic [W-1:0] sync1;
    logic [W-1:0] sync2;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int unsigned CNT_W =
        (clog2(DEBOUNCE_CYC) > 0) ? clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEBOUNCE_CYC - 1);

    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     deb_q;
    logic             hit;

    assign hit = (sync1 == sync2) && (cnt == CNT_END);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            deb_q <= '0;
        end else if (sync1 != sync2) begin
            cnt <= '0;
        end else if (cnt == CNT_END) begin
            cnt   <= '0;
            deb_q <= sync2;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign deb    = deb_q;
    assign change = hit && (deb_q != sync2);
`else
    localparam int unsigned unused_cyc = DEBOUNCE_CYC;

    assign deb    = sync2;
    assign change = (sync1 != sync2);
`endif

endmodule

// File: rtl/mmio_io_hub.sv
// mmio_io_hub: memory-mapped switch/LED hub with sticky change status and irq.
// Optional feature macro: IO_DEBOUNCE_EN (enables debounce counters in io_debounce).
// Ports:
//   clock, rst        : clock, asynchronous active-low reset
//   io_cs, addr       : window select, byte offset (addr[5] region, addr[4:2] channel)
//   rd_en, wr_en      : read / write strobes (qualified by io_cs)
//   wr_be, wr_data    : byte enables and write data
//   rd_data, rd_valid : registered read data and its one-cycle valid pulse
//   addr_err          : one-cycle pulse after an access to an unmapped channel
//   sw_in             : raw inputs, channel k at [k*IN_W +: IN_W]
//   out_bus           : output registers, channel k at [k*OUT_W +: OUT_W]
//   irq               : OR of all status bits
module mmio_io_hub
    import mmio_io_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned IN_W         = 16,
    parameter int unsigned OUT_W        = 16,
    parameter int unsigned N_IN         = 2,
    parameter int unsigned N_OUT        = 2,
    parameter int unsigned DEBOUNCE_CYC = 20000
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   io_cs,
    input  logic [5:0]             addr,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [DATA_W/8-1:0]    wr_be,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   addr_err,
    input  logic [N_IN*IN_W-1:0]   sw_in,
    output logic [N_OUT*OUT_W-1:0] out_bus,
    output logic                   irq
);

    logic [IN_W-1:0]  deb     [N_IN];
    logic [N_IN-1:0]  chg;
    logic [OUT_W-1:0] out_reg [N_OUT];
    logic [N_IN-1:0]  status;
    logic [N_IN-1:0]  clr;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] rd_val;
    logic              mapped;
    logic              rd_sel;
    logic              wr_sel;
    region_e           region;
    logic [2:0]        idx;
    logic              unused_ok;

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        io_debounce #(
            .W            (IN_W),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_deb (
            .clock  (clock),
            .rst    (rst),
            .raw    (sw_in[k*IN_W +: IN_W]),
            .deb    (deb[k]),
            .change (chg[k])
        );
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        assign out_bus[k*OUT_W +: OUT_W] = out_reg[k];
    end

    assign rd_sel    = io_cs & rd_en;
    assign wr_sel    = io_cs & wr_en;
    assign region    = region_e'(addr[REGION_BIT]);
    assign idx       = addr[IDX_HI:IDX_LO];
    assign irq       = |status;
    assign unused_ok = ^{addr[1:0], wr_data, lane_mask, wr_be};

    // Status decode comes last so that with N_IN=8 it shadows channel 7
    always_comb begin
        mapped = 1'b0;
        rd_val = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (region == REG_OUT && idx == 3'(k)) begin
                mapped = 1'b1;
                rd_val = DATA_W'(out_reg[k]);
            end
        end
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (region == REG_IN && idx == 3'(k)) begin
                mapped = 1'b1;
                rd_val = DATA_W'(deb[k]);
            end
        end
        if (region == REG_IN && idx == STATUS_IDX) begin
            mapped = 1'b1;
            rd_val = DATA_W'(status);
        end
    end

    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            lane_mask[i] = wr_be[i/8];
        end
    end

    always_comb begin
        clr = '0;
        if (wr_sel && region == REG_IN && idx == STATUS_IDX && wr_be[0]) begin
            clr = wr_data[N_IN-1:0];
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < N_OUT; k++) out_reg[k] <= '0;
        end else if (wr_sel && region == REG_OUT) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (idx == 3'(k)) begin
                    out_reg[k] <= (out_reg[k] & ~lane_mask[OUT_W-1:0])
                                | (wr_data[OUT_W-1:0] & lane_mask[OUT_W-1:0]);
                end
            end
        end
    end

    // Set has priority over write-1-to-clear
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) status <= '0;
        else      status <= (status & ~clr) | chg;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            if (rd_sel) rd_data <= rd_val;
            rd_valid <= rd_sel;
            addr_err <= (rd_sel | wr_sel) & ~mapped;
        end
    end

endmodule

// File: tb/tb_mmio_io_hub.sv
// tb_mmio_io_hub: directed scoreboard bench for mmio_io_hub (DEBOUNCE_CYC=4,
// N_IN=N_OUT=2, 16-bit channels, 32-bit bus). Honors IO_DEBOUNCE_EN.
module tb_mmio_io_hub;

`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        rst;
    logic        io_cs;
    logic [5:0]  addr;
    logic        rd_en;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        addr_err;
    logic [31:0] sw_in;
    logic [31:0] out_bus;
    logic        irq;

    typedef struct packed {
        logic        rd;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    mmio_io_hub #(
        .DATA_W       (32),
        .IN_W         (16),
        .OUT_W        (16),
        .N_IN         (2),
        .N_OUT        (2),
        .DEBOUNCE_CYC (4)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .io_cs    (io_cs),
        .addr     (addr),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .addr_err (addr_err),
        .sw_in    (sw_in),
        .out_bus  (out_bus),
        .irq      (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Called #1 after a posedge; the access is sampled on the next posedge.
    task automatic access(input logic cs, input logic [5:0] a, input logic rd, input logic wr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        if ((cs && rd) || exp_err) begin
            e.rd   = cs && rd;
            e.err  = exp_err;
            e.data = exp_data;
            q.push_back(e);
        end
        io_cs = cs; addr = a; rd_en = rd; wr_en = wr; wr_be = be; wr_data = wd;
        @(posedge clock);
        #1;
        io_cs = 1'b0; rd_en = 1'b0; wr_en = 1'b0; wr_be = '0; wr_data = '0; addr = '0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp_data, input logic exp_err);
        access(1'b1, a, 1'b1, 1'b0, 4'h0, 32'h0, exp_data, exp_err);
    endtask

    task automatic wr(input logic [5:0] a, input logic [3:0] be, input logic [31:0] wd,
                      input logic exp_err);
        access(1'b1, a, 1'b0, 1'b1, be, wd, 32'h0, exp_err);
    endtask

    // Monitor: every rd_valid / addr_err pulse must match the oldest expectation
    always @(negedge clock) begin
        exp_t e;
        if (rst === 1'b1 && (rd_valid !== 1'b0 || addr_err !== 1'b0)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: rd_valid=%b addr_err=%b rd_data=%h", rd_valid, addr_err, rd_data);
            end else begin
                e = q.pop_front();
                chk("rd_valid", {31'b0, rd_valid}, {31'b0, e.rd});
                chk("addr_err", {31'b0, addr_err}, {31'b0, e.err});
                if (e.rd) chk("rd_data", rd_data, e.data);
            end
        end
    end

    initial begin
        rst = 1'b0; io_cs = 1'b0; addr = '0; rd_en = 1'b0; wr_en = 1'b0;
        wr_be = '0; wr_data = '0; sw_in = 32'h0000_FFFF;

        // Reset state
        wait_cyc(3);
        chk("rst_out_bus", out_bus, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'h0);

        // Release; ch0 debounced value appears exactly LAT edges later
        rst = 1'b1;
        wait_cyc(LAT - 1);
        rd(6'h00, 32'h0000_0000, 1'b0);
        rd(6'h00, 32'h0000_FFFF, 1'b0);
        chk("irq_ch0", {31'b0, irq}, 32'h1);
        rd(6'h1C, 32'h1, 1'b0);
        wr(6'h1C, 4'b0001, 32'h1, 1'b0);
        rd(6'h1C, 32'h0, 1'b0);
        chk("irq_clr0", {31'b0, irq}, 32'h0);

`ifdef IO_DEBOUNCE_EN
        // 3-cycle glitch is rejected
        sw_in = 32'h0000_FFFE;
        wait_cyc(3);
        sw_in = 32'h0000_FFFF;
        wait_cyc(8);
        rd(6'h00, 32'h0000_FFFF, 1'b0);
        rd(6'h1C, 32'h0, 1'b0);
        chk("glitch_irq", {31'b0, irq}, 32'h0);
`endif

        // Byte-enable writes
        wr(6'h20, 4'b1111, 32'h0000_0005, 1'b0);
        wr(6'h24, 4'b0001, 32'h1234_ABCD, 1'b0);
        chk("be_out_bus", out_bus, 32'h00CD_0005);
        rd(6'h24, 32'h0000_00CD, 1'b0);
        wr(6'h24, 4'b1100, 32'hFFFF_FFFF, 1'b0);
        chk("be_upper_discard", out_bus, 32'h00CD_0005);
        wr(6'h24, 4'b0010, 32'h0000_1200, 1'b0);
        chk("be_lane1", out_bus, 32'h12CD_0005);

        // Status on ch1
        sw_in = 32'h0001_FFFF;
        wait_cyc(LAT + 1);
        chk("irq_ch1", {31'b0, irq}, 32'h1);
        rd(6'h1C, 32'h2, 1'b0);
        wr(6'h1C, 4'b0000, 32'h2, 1'b0);
        rd(6'h1C, 32'h2, 1'b0);
        wr(6'h1C, 4'b0001, 32'h2, 1'b0);
        rd(6'h1C, 32'h0, 1'b0);
        chk("irq_clr1", {31'b0, irq}, 32'h0);

        // Clear on the same edge as a new ch1 change: set wins
        sw_in = 32'h0003_FFFF;
        wait_cyc(LAT - 1);
        wr(6'h1C, 4'b0001, 32'h2, 1'b0);
        rd(6'h1C, 32'h2, 1'b0);
        chk("irq_setwins", {31'b0, irq}, 32'h1);
        rd(6'h04, 32'h0000_0003, 1'b0);
        wr(6'h1C, 4'b0001, 32'h2, 1'b0);
        rd(6'h1C, 32'h0, 1'b0);

        // Unmapped and ignored accesses
        wr(6'h28, 4'b1111, 32'hFFFF_FFFF, 1'b1);
        chk("unmapped_out_bus", out_bus, 32'h12CD_0005);
        rd(6'h28, 32'h0, 1'b1);
        rd(6'h08, 32'h0, 1'b1);
        wr(6'h00, 4'b1111, 32'h1234_5678, 1'b0);
        rd(6'h00, 32'h0000_FFFF, 1'b0);
        access(1'b0, 6'h20, 1'b1, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
        chk("nocs_out_bus", out_bus, 32'h12CD_0005);

        // Simultaneous read/write returns the old value
        access(1'b1, 6'h20, 1'b1, 1'b1, 4'b1111, 32'h0000_00AA, 32'h0000_0005, 1'b0);
        chk("rdwr_out_bus", out_bus, 32'h12CD_00AA);

        // Reset mid-stream, then channels restart from zero
        wait_cyc(2);
        rst = 1'b0;
        #1;
        chk("rst2_out_bus", out_bus, 32'h0);
        chk("rst2_irq", {31'b0, irq}, 32'h0);
        chk("rst2_rd_data", rd_data, 32'h0);
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(LAT - 1);
        rd(6'h00, 32'h0000_0000, 1'b0);
        rd(6'h00, 32'h0000_FFFF, 1'b0);
        rd(6'h04, 32'h0000_0003, 1'b0);

        wait_cyc(3);
        chk("queue_drained", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
